// File: rtl/karat_mult_arbiter.sv
// Round-robin front end that shares one Karatsuba multiplier among nREQ requesters.
// One job in flight at a time; the response channel is back-pressured and a watchdog aborts stuck jobs.
module karat_mult_arbiter #(
  parameter int wI      = 1024,
  parameter int nREQ    = 4,
  parameter int wID     = $clog2(nREQ),
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [nREQ-1:0]      req_valid,
  output logic [nREQ-1:0]      req_ready,
  input  logic [nREQ*wI-1:0]   req_x,
  input  logic [nREQ*wI-1:0]   req_y,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [wID-1:0]       rsp_id,
  output logic [2*wI-1:0]      rsp_data,
  output logic                 rsp_err,
  output logic                 m_enable,
  output logic [wI-1:0]        m_x,
  output logic [wI-1:0]        m_y,
  input  logic                 m_finish,
  input  logic [2*wI-1:0]      m_o,
  output logic                 busy,
  output logic                 err_timeout
);

  localparam int wCNT = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [wID-1:0]    ptr_q, ptr_d;
  logic [wID-1:0]    id_q, id_d;
  logic [wI-1:0]     x_q, x_d;
  logic [wI-1:0]     y_q, y_d;
  logic [2*wI-1:0]   data_q, data_d;
  logic              err_q, err_d;
  logic [wCNT-1:0]   cnt_q, cnt_d;

  logic              gnt_found;
  logic [wID-1:0]    gnt_idx;
  logic [wID-1:0]    scan_idx;
  logic              timeout_hit;

  // Search starts just after the last served requester, so it ends up lowest priority.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= nREQ; k++) begin
      scan_idx = wID'((int'(ptr_q) + k) % nREQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign timeout_hit = (cnt_q == wCNT'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    x_d         = x_q;
    y_d         = y_q;
    data_d      = data_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    err_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          // Gated by rst so no handshake is reported while the block is held in reset.
          req_ready[gnt_idx] = ~rst;
          x_d     = req_x[int'(gnt_idx)*wI +: wI];
          y_d     = req_y[int'(gnt_idx)*wI +: wI];
          id_d    = gnt_idx;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (m_finish) begin
          data_d  = m_o;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          data_d      = '0;
          err_d       = 1'b1;
          err_timeout = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          ptr_d   = id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= wID'(nREQ - 1);
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_enable  = (state_q == S_BUSY);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign m_x       = x_q;
  assign m_y       = y_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/karat_mult_arbiter.md
Name: karat_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one karat_mult_recursion instance among nREQ requesters. It accepts one operand pair at a time via valid/ready, drives the multiplier's enable and operand inputs, and waits for its finish pulse. It then returns the product with the requester ID on a single back-pressured response channel. A cycle watchdog flags a multiplier that never finishes.

Parameters:
wI, 1024, operand width; product width is 2*wI
nREQ, 4, number of requesters (2..16)
wID, $clog2(nREQ), requester ID width
TIMEOUT, 4096, max cycles in BUSY before abort (>=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  nREQ  per-requester request valid
req_ready  out  nREQ  per-requester accept, one-hot or zero
req_x  in  nREQ*wI  operand X, slice i belongs to requester i
req_y  in  nREQ*wI  operand Y, slice i belongs to requester i
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  wID  requester index of the response
rsp_data  out  2*wI  product
rsp_err  out  1  response is a timeout abort
m_enable  out  1  to multiplier i_enable
m_x  out  wI  to multiplier iX
m_y  out  wI  to multiplier iY
m_finish  in  1  from multiplier o_finish
m_o  in  2*wI  from multiplier oO
busy  out  1  high in BUSY or RESP
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high. On rst, immediately: state=IDLE, m_enable=0, rsp_valid=0, rsp_err=0, err_timeout=0, busy=0, req_ready=0, m_x/m_y/rsp_data/rsp_id/cycle counter=0, rr pointer=nREQ-1 (so requester 0 wins first).
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid, the winner g is the first set bit searching from ptr+1 upward, wrapping modulo nREQ.
  - req_ready[g]=1 combinationally; all other bits are 0. req_ready is 0 in every other state.
  - The handshake completes in the same cycle. Register x/y from slice g and id=g, clear the counter, go to BUSY.
  - Requesters may drop req_valid while not accepted without penalty.
- BUSY:
  - m_enable=1; m_x/m_y driven from the registers and held stable for the whole state.
  - Counter increments each cycle.
  - If m_finish=1: rsp_data<=m_o, rsp_err<=0, go to RESP. m_enable is 0 from the next cycle.
  - Else if counter==TIMEOUT-1: rsp_data<=0, rsp_err<=1, err_timeout pulses 1 cycle, go to RESP.
  - If m_finish arrives in the same cycle as the timeout, m_finish wins.
- RESP:
  - rsp_valid=1; rsp_id/rsp_data/rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: ptr<=rsp_id, go to IDLE.
  - No new grant is issued in the handshake cycle. The minimum spacing between grants is 1 IDLE cycle.
- m_finish outside BUSY is ignored and changes no state.
- Latency: grant cycle -> BUSY -> rsp_valid rises the cycle after m_finish is sampled.
- Fairness: a continuously requesting requester is served within nREQ transactions.
- m_enable is low in IDLE and RESP, so the multiplier never starts a new operation unowned.
- Reset mid-operation abandons the job: no response, and the multiplier is disabled at once.

Test Plan:
1. Reset, then req_valid[0] with x=3, y=5; stub multiplier returns finish after 7 cycles -> rsp_valid with rsp_id=0, rsp_data=15, rsp_err=0; req_ready[0] high exactly 1 cycle.
2. req_valid[3:0]=4'b1111 held continuously with distinct random operands, real karat_mult_recursion (wI=1024, nSTAGE=5) -> grants in order 0,1,2,3,0…; every rsp_data equals the 2048-bit reference product, 200 transactions.
3. Only requesters 1 and 3 valid after requester 2 was last served -> order 3,1,3,1; requester 0 raising valid mid-stream is served within 4 grants.
4. rsp_ready held low 20 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable; m_enable=0; no req_ready; grant resumes 1 cycle after rsp_ready.
5. TIMEOUT=16, stub never asserts m_finish -> err_timeout pulse at cycle 16 of BUSY; response with rsp_err=1, rsp_data=0. A spurious m_finish while in IDLE leaves busy=0.
6. Assert rst for 1 cycle mid-BUSY -> m_enable, busy, rsp_valid fall asynchronously before the next edge; the next grant goes to requester 0.
